// File: rtl/perf_pkg.sv
// Shared types for the perf measurement-window scheduler: FSM states and the
// history sample format captured at the end of each window.
package perf_pkg;

  localparam int PERF_COUNTER_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_STOP,
    ST_WAIT_DONE,
    ST_CAPTURE
  } perf_win_state_e;

  typedef struct packed {
    logic [PERF_COUNTER_WIDTH-1:0] total;
    logic [PERF_COUNTER_WIDTH-1:0] active;
    logic [PERF_COUNTER_WIDTH-1:0] idle;
    logic [7:0]                    win_idx;
  } perf_sample_t;

endpackage

// File: rtl/perf_window_ctrl_if.sv
// Host read port of the sample history: valid/ready handshake plus head sample.
interface perf_window_ctrl_if
  import perf_pkg::*;
#(
  parameter int COUNTER_WIDTH = PERF_COUNTER_WIDTH
);
  logic                     valid;
  logic                     ready;
  logic [COUNTER_WIDTH-1:0] total;
  logic [COUNTER_WIDTH-1:0] active;
  logic [COUNTER_WIDTH-1:0] idle;
  logic [7:0]               win_idx;

  modport master (output valid, total, active, idle, win_idx, input ready);
  modport slave  (input valid, total, active, idle, win_idx, output ready);
endinterface

// File: rtl/perf_hist_fifo.sv
// Sample history FIFO; a push into a full FIFO is dropped and flagged unless a
// pop in the same cycle frees the slot.
module perf_hist_fifo
  import perf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  perf_sample_t push_data,
  input  logic         pop,
  output perf_sample_t head,
  output logic         empty,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);

  perf_sample_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           full;
  logic           pop_ok;
  logic           push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;
  assign head    = mem[rd_ptr];

  // When full, wr_ptr == rd_ptr: a simultaneous push/pop rewrites the slot
  // being retired, which then becomes the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/perf_window_ctrl.sv
// Runs back-to-back fixed-length perf measurement windows and logs each
// window's counts into a history FIFO drained by the host.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   ST_IDLE      | waiting for cfg_start
//   ST_START     | perf_start_pulse, window counter loaded with len-1
//   ST_RUN       | counting the window down
//   ST_STOP      | perf_done_pulse, timeout counter loaded
//   ST_WAIT_DONE | waiting for perf_measurement_done (or timeout)
//   ST_CAPTURE   | push sample, bump win_count, next window or IDLE
module perf_window_ctrl
  import perf_pkg::*;
#(
  parameter int COUNTER_WIDTH = PERF_COUNTER_WIDTH,
  parameter int WIN_WIDTH     = 16,
  parameter int HIST_DEPTH    = 4,
  parameter int DONE_TIMEOUT  = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_start,
  input  logic                     cfg_abort,
  input  logic [WIN_WIDTH-1:0]     cfg_win_len,
  input  logic [7:0]               cfg_num_win,
  output logic                     perf_start_pulse,
  output logic                     perf_done_pulse,
  input  logic                     perf_measurement_done,
  input  logic [COUNTER_WIDTH-1:0] perf_total,
  input  logic [COUNTER_WIDTH-1:0] perf_active,
  input  logic [COUNTER_WIDTH-1:0] perf_idle,
  perf_window_ctrl_if.master       rd,
  output logic                     busy,
  output logic [7:0]               win_count,
  output logic                     overflow_err,
  output logic                     timeout_err
);
  localparam int TMO_WIDTH = $clog2(DONE_TIMEOUT + 1);

  perf_win_state_e      state;
  perf_win_state_e      state_nxt;
  logic [WIN_WIDTH-1:0] len_q;
  logic [WIN_WIDTH-1:0] win_cnt;
  logic [7:0]           num_q;
  logic [TMO_WIDTH-1:0] tmo_cnt;
  logic [7:0]           win_count_inc;
  logic                 abort_pending;
  logic                 abort_now;
  logic                 start_accept;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic                 fifo_empty;
  logic                 tmo_fire;
  perf_sample_t         sample;
  perf_sample_t         head;

  assign abort_now     = abort_pending | cfg_abort;
  assign start_accept  = (state == ST_IDLE) && cfg_start;
  assign win_count_inc = win_count + 8'd1;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    tmo_fire  = 1'b0;
    case (state)
      ST_IDLE:      if (cfg_start) state_nxt = ST_START;
      ST_START:     state_nxt = (abort_now || len_q == WIN_WIDTH'(1)) ? ST_STOP : ST_RUN;
      ST_RUN:       if (abort_now || win_cnt == WIN_WIDTH'(1)) state_nxt = ST_STOP;
      ST_STOP:      state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (perf_measurement_done) begin
          state_nxt = ST_CAPTURE;
        end else if (tmo_cnt == TMO_WIDTH'(1)) begin
          tmo_fire  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        push = 1'b1;
        if (abort_now || (num_q != 8'd0 && win_count_inc == num_q)) state_nxt = ST_IDLE;
        else                                                        state_nxt = ST_START;
      end
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      len_q         <= '0;
      num_q         <= '0;
      win_cnt       <= '0;
      tmo_cnt       <= '0;
      win_count     <= '0;
      abort_pending <= 1'b0;
      overflow_err  <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_accept) begin
        len_q        <= (cfg_win_len == '0) ? WIN_WIDTH'(1) : cfg_win_len;
        num_q        <= cfg_num_win;
        win_count    <= '0;
        overflow_err <= 1'b0;
        timeout_err  <= 1'b0;
      end else begin
        if (tmo_fire) timeout_err  <= 1'b1;
        if (drop)     overflow_err <= 1'b1;
        if (state == ST_CAPTURE) win_count <= win_count_inc;
      end
      case (state)
        ST_START:     win_cnt <= len_q - WIN_WIDTH'(1);
        ST_RUN:       win_cnt <= win_cnt - WIN_WIDTH'(1);
        ST_STOP:      tmo_cnt <= TMO_WIDTH'(DONE_TIMEOUT - 1);
        ST_WAIT_DONE: tmo_cnt <= tmo_cnt - TMO_WIDTH'(1);
        default:      ;
      endcase
      if (state_nxt == ST_IDLE)                  abort_pending <= 1'b0;
      else if (cfg_abort && state != ST_IDLE)    abort_pending <= 1'b1;
    end
  end

  assign perf_start_pulse = (state == ST_START);
  assign perf_done_pulse  = (state == ST_STOP);
  assign busy             = (state != ST_IDLE);

  assign sample = '{total: perf_total, active: perf_active, idle: perf_idle, win_idx: win_count};
  assign pop    = rd.valid && rd.ready;

  perf_hist_fifo #(.DEPTH(HIST_DEPTH)) u_hist (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (sample),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .drop      (drop)
  );

  assign rd.valid   = !fifo_empty;
  assign rd.total   = head.total;
  assign rd.active  = head.active;
  assign rd.idle    = head.idle;
  assign rd.win_idx = head.win_idx;

endmodule

// File: tb/tb_perf_window_ctrl.sv
// Bench for perf_window_ctrl with a behavioural perf stand-in and
// expectations computed from window length, count and perf latency.
module tb_perf_window_ctrl;
  import perf_pkg::*;

  localparam int DT = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start, cfg_abort;
  logic [15:0] cfg_win_len;
  logic [7:0]  cfg_num_win;
  logic        perf_start_pulse, perf_done_pulse;
  logic        perf_measurement_done = 1'b0;
  logic [31:0] perf_total = '0, perf_active = '0, perf_idle = '0;
  logic        busy, overflow_err, timeout_err;
  logic [7:0]  win_count;

  logic        perf_busy, mdone_en;
  int unsigned mdone_lat;
  logic        running = 1'b0;
  int unsigned dly = 0;
  int          cyc = 0;
  int          checks = 0, errors = 0;

  int           start_q[$];
  int           done_q[$];
  perf_sample_t got_q[$];

  perf_window_ctrl_if rd_if ();

  perf_window_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_win_len(cfg_win_len), .cfg_num_win(cfg_num_win),
    .perf_start_pulse(perf_start_pulse), .perf_done_pulse(perf_done_pulse),
    .perf_measurement_done(perf_measurement_done), .perf_total(perf_total),
    .perf_active(perf_active), .perf_idle(perf_idle), .rd(rd_if), .busy(busy),
    .win_count(win_count), .overflow_err(overflow_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // perf stand-in: counts every cycle from the start pulse up to (not incl.)
  // the done pulse, then raises measurement_done mdone_lat cycles later.
  always @(posedge clk) begin
    perf_measurement_done <= 1'b0;
    if (perf_start_pulse) begin
      perf_total  <= 32'd1;
      perf_active <= {31'd0, perf_busy};
      perf_idle   <= {31'd0, !perf_busy};
      running     <= 1'b1;
    end else if (running && !perf_done_pulse) begin
      perf_total  <= perf_total + 32'd1;
      perf_active <= perf_active + {31'd0, perf_busy};
      perf_idle   <= perf_idle + {31'd0, !perf_busy};
    end
    if (perf_done_pulse) begin
      running <= 1'b0;
      if (mdone_en) begin
        if (mdone_lat <= 1) perf_measurement_done <= 1'b1;
        else                dly <= mdone_lat - 1;
      end
    end else if (dly != 0) begin
      dly <= dly - 1;
      if (dly == 1) perf_measurement_done <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (perf_start_pulse) start_q.push_back(cyc);
    if (perf_done_pulse)  done_q.push_back(cyc);
    if (rd_if.valid && rd_if.ready)
      got_q.push_back(perf_sample_t'{total: rd_if.total, active: rd_if.active,
                                     idle: rd_if.idle, win_idx: rd_if.win_idx});
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    start_q.delete();
    done_q.delete();
    got_q.delete();
  endtask

  task automatic run_seq(input int len, input int num, input logic bz, input int lat, input logic rdy);
    cfg_win_len = 16'(len);
    cfg_num_win = 8'(num);
    perf_busy   = bz;
    mdone_lat   = lat;
    rd_if.ready = rdy;
    cfg_start   = 1'b1;
    tick();
    cfg_start   = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%0b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, perf_start_pulse, perf_done_pulse, rd_if.valid, overflow_err, timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 000000",
               {busy, perf_start_pulse, perf_done_pulse, rd_if.valid, overflow_err, timeout_err});
    end
    checks++;
    if ({rd_if.total, rd_if.active, rd_if.idle, rd_if.win_idx, win_count} !== '0) begin
      errors++;
      $display("FAIL reset_data: rd/win_count nonzero (total=%0d idx=%0d win_count=%0d), required 0",
               rd_if.total, rd_if.win_idx, win_count);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: got %0b, required 0", busy);
    end
  endtask

  task automatic test_single_window();
    clear_logs();
    run_seq(100, 1, 1'b1, 3, 1'b1);
    wait_idle(400, "single");
    repeat (3) tick();
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL single_count: got %0d samples, required 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      checks++;
      if (got_q[0] !== perf_sample_t'{total: 100, active: 100, idle: 0, win_idx: 0}) begin
        errors++;
        $display("FAIL single_sample: got %0d/%0d/%0d idx %0d, required 100/100/0 idx 0",
                 got_q[0].total, got_q[0].active, got_q[0].idle, got_q[0].win_idx);
      end
    end
    if (start_q.size() > 0 && done_q.size() > 0) begin
      checks++;
      if (done_q[0] - start_q[0] != 100) begin
        errors++;
        $display("FAIL single_done_gap: got %0d cycles, required 100", done_q[0] - start_q[0]);
      end
    end
    checks++;
    if (win_count !== 8'd1 || start_q.size() != 1) begin
      errors++;
      $display("FAIL single_win_count: got %0d (starts %0d), required 1 (starts 1)", win_count, start_q.size());
    end
  endtask

  task automatic test_multi_window();
    for (int it = 0; it < 7; it++) begin
      int len, num, lat, eff;
      logic bz;
      perf_sample_t exp_q[$];
      len = (it == 0) ? 10 : int'($urandom_range(0, 30));
      num = (it == 0) ? 3  : int'($urandom_range(1, 5));
      lat = (it == 0) ? 2  : int'($urandom_range(1, 6));
      bz  = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      eff = (len == 0) ? 1 : len;
      for (int k = 0; k < num; k++)
        exp_q.push_back(perf_sample_t'{total: eff, active: bz ? eff : 0, idle: bz ? 0 : eff, win_idx: k});
      clear_logs();
      run_seq(len, num, bz, lat, 1'b1);
      wait_idle(num * (eff + lat + 4) + 50, "multi");
      repeat (4) tick();
      checks++;
      if (got_q.size() != num) begin
        errors++;
        $display("FAIL multi_count[%0d]: got %0d samples, required %0d", it, got_q.size(), num);
      end
      for (int k = 0; k < num && k < got_q.size(); k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL multi_sample[%0d][%0d]: got %0d/%0d/%0d idx %0d, required %0d/%0d/%0d idx %0d",
                   it, k, got_q[k].total, got_q[k].active, got_q[k].idle, got_q[k].win_idx,
                   exp_q[k].total, exp_q[k].active, exp_q[k].idle, exp_q[k].win_idx);
        end
      end
      for (int k = 1; k < start_q.size(); k++) begin
        checks++;
        if (start_q[k] - start_q[k-1] != eff + lat + 2) begin
          errors++;
          $display("FAIL multi_spacing[%0d][%0d]: got %0d, required %0d",
                   it, k, start_q[k] - start_q[k-1], eff + lat + 2);
        end
      end
      for (int k = 0; k < done_q.size() && k < start_q.size(); k++) begin
        checks++;
        if (done_q[k] - start_q[k] != eff) begin
          errors++;
          $display("FAIL multi_done_gap[%0d][%0d]: got %0d, required %0d", it, k, done_q[k] - start_q[k], eff);
        end
      end
      checks++;
      if (win_count !== 8'(num) || start_q.size() != num) begin
        errors++;
        $display("FAIL multi_win_count[%0d]: got %0d (starts %0d), required %0d", it, win_count, start_q.size(), num);
      end
    end
  endtask

  task automatic test_overflow();
    int n, md;
    clear_logs();
    run_seq(8, 6, 1'b1, 2, 1'b0);
    n = 0;
    while (!overflow_err && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (overflow_err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ovf_rise: overflow_err=%0b busy=%0b, required 1 and 1", overflow_err, busy);
    end
    // a second start while busy must not restart or clear the sticky
    cfg_num_win = 8'd1;
    cfg_start   = 1'b1;
    tick();
    cfg_start   = 1'b0;
    wait_idle(200, "ovf");
    checks++;
    if ({rd_if.valid, overflow_err} !== 2'b11 || win_count !== 8'd6) begin
      errors++;
      $display("FAIL ovf_state: valid=%0b overflow_err=%0b win_count=%0d, required 1 1 6",
               rd_if.valid, overflow_err, win_count);
    end
    rd_if.ready = 1'b1;
    repeat (8) tick();
    rd_if.ready = 1'b0;
    checks++;
    if (got_q.size() != 4 || rd_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drain_count: got %0d samples valid=%0b, required 4 valid=0", got_q.size(), rd_if.valid);
    end
    for (int k = 0; k < got_q.size(); k++) begin
      checks++;
      if (got_q[k].win_idx !== 8'(k) || got_q[k].total !== 32'd8) begin
        errors++;
        $display("FAIL ovf_drain[%0d]: got idx %0d total %0d, required idx %0d total 8", k, got_q[k].win_idx, got_q[k].total, k);
      end
    end

    // FIFO full at the fifth capture; one pop in that exact cycle avoids overflow
    clear_logs();
    run_seq(8, 5, 1'b1, 2, 1'b0);
    n  = 0;
    md = 0;
    while (md < 5 && n < 500) begin
      tick();
      n++;
      if (perf_measurement_done === 1'b1) md++;
    end
    checks++;
    if (md != 5) begin
      errors++;
      $display("FAIL ovf_wait_mdone: got %0d done events, required 5", md);
    end
    tick();
    rd_if.ready = 1'b1;
    tick();
    rd_if.ready = 1'b0;
    wait_idle(50, "ovf2");
    checks++;
    if (overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pushpop: overflow_err=%0b, required 0", overflow_err);
    end
    rd_if.ready = 1'b1;
    repeat (8) tick();
    rd_if.ready = 1'b0;
    checks++;
    if (got_q.size() != 5) begin
      errors++;
      $display("FAIL ovf_pushpop_count: got %0d samples, required 5", got_q.size());
    end
    for (int k = 0; k < got_q.size(); k++) begin
      checks++;
      if (got_q[k].win_idx !== 8'(k)) begin
        errors++;
        $display("FAIL ovf_pushpop_idx[%0d]: got %0d, required %0d", k, got_q[k].win_idx, k);
      end
    end
  endtask

  task automatic test_abort();
    int n = 0;
    int s;
    clear_logs();
    run_seq(1000, 0, 1'b1, 2, 1'b1);
    while (start_q.size() == 0 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (start_q.size() == 0) begin
      errors++;
      $display("FAIL abort_start: got no start pulse, required 1");
      return;
    end
    s = start_q[0];
    while (cyc < s + 20) tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    wait_idle(50, "abort");
    repeat (50) tick();
    checks++;
    if (done_q.size() != 1 || (done_q.size() > 0 && done_q[0] - s != 21)) begin
      errors++;
      $display("FAIL abort_done: got %0d done pulses first at +%0d, required 1 at +21",
               done_q.size(), done_q.size() > 0 ? done_q[0] - s : -1);
    end
    checks++;
    if (got_q.size() != 1 || (got_q.size() > 0 && got_q[0] !== perf_sample_t'{total: 21, active: 21, idle: 0, win_idx: 0})) begin
      errors++;
      $display("FAIL abort_sample: got %0d samples total %0d, required 1 sample 21/21/0 idx 0",
               got_q.size(), got_q.size() > 0 ? got_q[0].total : 0);
    end
    checks++;
    if (start_q.size() != 1 || busy !== 1'b0 || win_count !== 8'd1) begin
      errors++;
      $display("FAIL abort_end: starts=%0d busy=%0b win_count=%0d, required 1 0 1", start_q.size(), busy, win_count);
    end
  endtask

  task automatic test_timeout_edge();
    int n = 0;
    int t = 0;
    logic b = 1'b1;
    clear_logs();
    mdone_en = 1'b0;
    run_seq(5, 2, 1'b0, 1, 1'b1);
    while (!timeout_err && n < 400) begin
      tick();
      n++;
      t = cyc;
      b = busy;
    end
    repeat (3) tick();
    checks++;
    if (timeout_err !== 1'b1 || done_q.size() != 1 || (done_q.size() > 0 && t - done_q[0] != DT)) begin
      errors++;
      $display("FAIL timeout_timing: err=%0b done pulses=%0d delay %0d, required 1 1 %0d",
               timeout_err, done_q.size(), done_q.size() > 0 ? t - done_q[0] : -1, DT);
    end
    checks++;
    if (b !== 1'b0 || busy !== 1'b0 || got_q.size() != 0 || win_count !== 8'd0 || start_q.size() != 1) begin
      errors++;
      $display("FAIL timeout_state: busy@err=%0b samples=%0d win_count=%0d starts=%0d, required 0 0 0 1",
               b, got_q.size(), win_count, start_q.size());
    end
    mdone_en = 1'b1;
    clear_logs();
    run_seq(0, 1, 1'b1, 1, 1'b1);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %0b, required 0", timeout_err);
    end
    wait_idle(50, "len0");
    repeat (3) tick();
    checks++;
    if (got_q.size() != 1 || (got_q.size() > 0 && got_q[0] !== perf_sample_t'{total: 1, active: 1, idle: 0, win_idx: 0})) begin
      errors++;
      $display("FAIL len0_sample: got %0d samples total %0d, required 1 sample total 1",
               got_q.size(), got_q.size() > 0 ? got_q[0].total : 0);
    end
  endtask

  task automatic test_reset_mid_run();
    int n = 0;
    clear_logs();
    run_seq(20, 3, 1'b0, 2, 1'b0);
    while (start_q.size() < 2 && n < 100) begin
      tick();
      n++;
    end
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, perf_start_pulse, perf_done_pulse, rd_if.valid, overflow_err, timeout_err} !== 6'b0 ||
        {rd_if.total, rd_if.win_idx, win_count} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%0b valid=%0b win_count=%0d total=%0d, required all 0",
               busy, rd_if.valid, win_count, rd_if.total);
    end
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    checks++;
    if (start_q.size() != 2 || done_q.size() != 1 || busy !== 1'b0 || rd_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet: starts=%0d dones=%0d busy=%0b valid=%0b, required 2 1 0 0",
               start_q.size(), done_q.size(), busy, rd_if.valid);
    end
    clear_logs();
    run_seq(7, 2, 1'b1, 3, 1'b1);
    wait_idle(100, "midreset");
    repeat (4) tick();
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL midreset_rerun_count: got %0d samples, required 2", got_q.size());
    end
    for (int k = 0; k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] !== perf_sample_t'{total: 7, active: 7, idle: 0, win_idx: k}) begin
        errors++;
        $display("FAIL midreset_rerun[%0d]: got %0d/%0d/%0d idx %0d, required 7/7/0 idx %0d",
                 k, got_q[k].total, got_q[k].active, got_q[k].idle, got_q[k].win_idx, k);
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    cfg_start   = 1'b0;
    cfg_abort   = 1'b0;
    cfg_win_len = '0;
    cfg_num_win = '0;
    rd_if.ready = 1'b0;
    perf_busy   = 1'b0;
    mdone_lat   = 1;
    mdone_en    = 1'b1;
    test_reset();
    test_single_window();
    test_multi_window();
    test_overflow();
    test_abort();
    test_timeout_edge();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
